// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanning, debouncing 4x4 hex keypad reader.
// Drives one active-low column at a time, synchronizes the active-low rows,
// debounces a single pressed key and shifts its hex code into a 32-bit
// number register that can feed the 8-digit display driver directly.
//
// Optional build macro: KEYPAD_CLEAR_KEY_EN
//   defined   -> key D clears the number register instead of shifting in
//   undefined -> key D shifts in like every other key
module keypad_scanner #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_TICKS = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_down,
  output logic [31:0] number
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [DIV_W-1:0]  div_cnt;
  logic              tick;

  logic [3:0]        row_meta;
  logic [3:0]        rs;

  logic [1:0]        col_idx;
  logic [1:0]        col_idx_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [CNT_W-1:0]  cnt_inc;
  logic [3:0]        pattern;
  logic [3:0]        pattern_next;

  logic              key_valid_next;
  logic [3:0]        key_code_next;
  logic              key_down_next;
  logic [31:0]       number_next;

  logic              single_zero;
  logic [1:0]        row_idx;
  logic [3:0]        pressed_code;

  // Hex legend of the keypad, row-major; the bottom row reads 0 F E D.
  function automatic logic [3:0] decode_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  // Free-running scan-tick divider; the tick paces both column stepping and
  // debounce sampling, giving each new column SCAN_DIV clocks to settle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  // Two-flop synchronizer on the asynchronous row lines; idle rows read high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_meta <= 4'b1111;
      rs       <= 4'b1111;
    end else begin
      row_meta <= row;
      rs       <= row_meta;
    end
  end

  // A valid press shows exactly one low row; anything else is idle or ghosting.
  always_comb begin
    single_zero = 1'b0;
    case (rs)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: single_zero = 1'b1;
      default:                            single_zero = 1'b0;
    endcase
  end

  // Row index of the captured key, recovered from the saved one-cold pattern.
  always_comb begin
    row_idx = 2'd0;
    case (pattern)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  assign pressed_code = decode_key(row_idx, col_idx);
  assign cnt_inc      = cnt + CNT_ONE;

  // Next-state and next-output logic for the scan / debounce / accept / release cycle.
  always_comb begin
    state_next     = state;
    col_idx_next   = col_idx;
    cnt_next       = cnt;
    pattern_next   = pattern;
    key_valid_next = 1'b0;
    key_code_next  = key_code;
    key_down_next  = key_down;
    number_next    = number;

    case (state)
      SCAN: begin
        if (tick) begin
          if (single_zero) begin
            pattern_next = rs;
            cnt_next     = CNT_ONE;
            state_next   = (DEBOUNCE_TICKS == 1) ? PRESSED : DEBOUNCE;
          end else begin
            col_idx_next = col_idx + 2'd1;
          end
        end
      end

      DEBOUNCE: begin
        if (tick) begin
          if (rs == pattern) begin
            cnt_next = cnt_inc;
            if (cnt_inc == CNT_LIMIT) begin
              state_next = PRESSED;
            end
          end else begin
            col_idx_next = col_idx + 2'd1;
            state_next   = SCAN;
          end
        end
      end

      PRESSED: begin
        key_valid_next = 1'b1;
        key_code_next  = pressed_code;
        number_next    = {number[27:0], pressed_code};
`ifdef KEYPAD_CLEAR_KEY_EN
        if (pressed_code == 4'hD) begin
          number_next = '0;
        end
`endif
        key_down_next  = 1'b1;
        cnt_next       = '0;
        state_next     = RELEASE;
      end

      RELEASE: begin
        if (tick) begin
          if (rs == 4'b1111) begin
            if (cnt_inc == CNT_LIMIT) begin
              cnt_next      = '0;
              key_down_next = 1'b0;
              col_idx_next  = col_idx + 2'd1;
              state_next    = SCAN;
            end else begin
              cnt_next = cnt_inc;
            end
          end else begin
            cnt_next = '0;
          end
        end
      end

      default: begin
        state_next = SCAN;
      end
    endcase
  end

  // State and output registers; col is registered from the next column index
  // so the drive always matches col_idx with no decode glitches on the pins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      col       <= 4'b1110;
      cnt       <= '0;
      pattern   <= 4'b1111;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      key_down  <= 1'b0;
      number    <= '0;
    end else begin
      state     <= state_next;
      col_idx   <= col_idx_next;
      col       <= ~(4'b0001 << col_idx_next);
      cnt       <= cnt_next;
      pattern   <= pattern_next;
      key_valid <= key_valid_next;
      key_code  <= key_code_next;
      key_down  <= key_down_next;
      number    <= number_next;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a behavioural
// 4x4 keypad model (a pressed key pulls its row low while its column is driven).
module tb_keypad_scanner;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_TICKS = 3;
  localparam int WAIT_LIMIT     = 150;

  logic        clock;
  logic        reset_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_down;
  logic [31:0] number;

  logic [3:0][3:0] key_mat;

  int checks;
  int failures;
  int valid_count;
  logic [3:0]  cap_code;
  logic [31:0] cap_number;
  logic        cap_down;

  typedef struct {
    logic [1:0]  r;
    logic [1:0]  c;
    logic [3:0]  exp_code;
    logic [31:0] exp_number;
  } key_vec_t;

  key_vec_t vecs [16];

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_down  (key_down),
    .number    (number)
  );

  // 100 MHz-style clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Keypad model: row r goes low when any pressed key in it sits on a driven column.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      if (|(key_mat[r] & ~col)) row[r] = 1'b0;
    end
  end

  // Accept monitor, sampled just after each rising edge.
  always @(posedge clock) begin
    #1;
    if (key_valid === 1'b1) begin
      valid_count = valid_count + 1;
      cap_code    = key_code;
      cap_number  = number;
      cap_down    = key_down;
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic wait_for_valid(input string name);
    int n;
    n = 0;
    while (valid_count == 0 && n < WAIT_LIMIT) begin
      @(negedge clock);
      n++;
    end
    check_output({name, " accept seen"}, 32'(valid_count > 0), 32'd1);
  endtask

  task automatic wait_for_release(input string name, output int cycles);
    cycles = 0;
    while (key_down === 1'b1 && cycles < WAIT_LIMIT) begin
      @(posedge clock);
      #1;
      cycles++;
    end
    check_output({name, " key_down cleared"}, 32'(key_down), 32'd0);
  endtask

  task automatic count_col_steps(input int n_cycles, output int steps);
    logic [3:0] prev;
    prev  = col;
    steps = 0;
    for (int i = 0; i < n_cycles; i++) begin
      @(negedge clock);
      if (col !== prev) steps++;
      prev = col;
    end
  endtask

  // Press one key, hold it until accepted plus a little, release and wait out the release.
  task automatic apply_stimulus(input logic [1:0] r, input logic [1:0] c, input string name);
    int cyc;
    @(negedge clock);
    valid_count = 0;
    key_mat[r][c] = 1'b1;
    wait_for_valid(name);
    repeat (8) @(negedge clock);
    key_mat[r][c] = 1'b0;
    wait_for_release(name, cyc);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int cyc;
    int steps;
    logic [3:0] exp_cols [4];

    checks      = 0;
    failures    = 0;
    valid_count = 0;
    cap_code    = '0;
    cap_number  = '0;
    cap_down    = 1'b0;
    key_mat     = '0;
    reset_n     = 1'b0;

    vecs[0]  = '{2'd0, 2'd0, 4'h1, 32'h0000_0001};
    vecs[1]  = '{2'd0, 2'd1, 4'h2, 32'h0000_0012};
    vecs[2]  = '{2'd0, 2'd2, 4'h3, 32'h0000_0123};
    vecs[3]  = '{2'd0, 2'd3, 4'hA, 32'h0000_123A};
    vecs[4]  = '{2'd1, 2'd0, 4'h4, 32'h0001_23A4};
    vecs[5]  = '{2'd1, 2'd1, 4'h5, 32'h0012_3A45};
    vecs[6]  = '{2'd1, 2'd2, 4'h6, 32'h0123_A456};
    vecs[7]  = '{2'd1, 2'd3, 4'hB, 32'h123A_456B};
    vecs[8]  = '{2'd2, 2'd0, 4'h7, 32'h23A4_56B7};
    vecs[9]  = '{2'd2, 2'd1, 4'h8, 32'h3A45_6B78};
    vecs[10] = '{2'd2, 2'd2, 4'h9, 32'hA456_B789};
    vecs[11] = '{2'd2, 2'd3, 4'hC, 32'h456B_789C};
    vecs[12] = '{2'd3, 2'd0, 4'h0, 32'h56B7_89C0};
    vecs[13] = '{2'd3, 2'd1, 4'hF, 32'h6B78_9C0F};
    vecs[14] = '{2'd3, 2'd2, 4'hE, 32'hB789_C0FE};
    vecs[15] = '{2'd3, 2'd3, 4'hD, 32'h789C_0FED};
`ifdef KEYPAD_CLEAR_KEY_EN
    vecs[15].exp_number = 32'h0000_0000;
`endif

    exp_cols[0] = 4'b1101;
    exp_cols[1] = 4'b1011;
    exp_cols[2] = 4'b0111;
    exp_cols[3] = 4'b1110;

    // Reset values.
    repeat (3) @(negedge clock);
    check_output("reset col", 32'(col), 32'(4'b1110));
    check_output("reset key_valid", 32'(key_valid), 32'd0);
    check_output("reset key_code", 32'(key_code), 32'd0);
    check_output("reset key_down", 32'(key_down), 32'd0);
    check_output("reset number", number, 32'd0);

    // Idle column rotation: one step every SCAN_DIV clocks.
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] prev;
      prev = col;
      cyc  = 0;
      while (col === prev && cyc < 20) begin
        @(posedge clock);
        #1;
        cyc++;
      end
      check_output($sformatf("col step %0d value", i), 32'(col), 32'(exp_cols[i]));
      check_output($sformatf("col step %0d period", i), cyc, SCAN_DIV);
    end

    // Hold key 5 for 40 clocks: exactly one accept, release timing bounded.
    @(negedge clock);
    valid_count = 0;
    key_mat[1][1] = 1'b1;
    repeat (40) @(negedge clock);
    key_mat[1][1] = 1'b0;
    wait_for_release("key5", cyc);
    check_output("key5 accept count", valid_count, 1);
    check_output("key5 key_code", 32'(cap_code), 32'h5);
    check_output("key5 number", cap_number, 32'h0000_0005);
    check_output("key5 key_down at accept", 32'(cap_down), 32'd1);
    check_output("key5 release delay in window",
                 32'(cyc >= SCAN_DIV * (DEBOUNCE_TICKS - 1) + 3 && cyc <= SCAN_DIV * DEBOUNCE_TICKS + 2), 32'd1);

    // Key 7 bouncing one tick low, one tick high: never accepted.
    repeat (10) @(negedge clock);
    valid_count = 0;
    for (int i = 0; i < 12; i++) begin
      key_mat[2][0] = 1'b1;
      repeat (SCAN_DIV) @(negedge clock);
      key_mat[2][0] = 1'b0;
      repeat (SCAN_DIV) @(negedge clock);
    end
    count_col_steps(40, steps);
    check_output("bounce accept count", valid_count, 0);
    check_output("bounce key_down", 32'(key_down), 32'd0);
    check_output("bounce scan resumes", 32'(steps >= 8), 32'd1);
    check_output("bounce number unchanged", number, 32'h0000_0005);

    // Rows 0 and 2 low together on column 1: rejected as ghosting.
    valid_count = 0;
    key_mat[0][1] = 1'b1;
    key_mat[2][1] = 1'b1;
    count_col_steps(100, steps);
    check_output("ghost accept count", valid_count, 0);
    check_output("ghost col keeps rotating", 32'(steps >= 20), 32'd1);
    key_mat = '0;
    repeat (10) @(negedge clock);

    // Reset during release of key A, key still held afterwards.
    valid_count = 0;
    key_mat[0][3] = 1'b1;
    wait_for_valid("keyA first");
    repeat (3) @(negedge clock);
    check_output("keyA held key_down", 32'(key_down), 32'd1);
    reset_n = 1'b0;
    #1;
    check_output("mid reset col", 32'(col), 32'(4'b1110));
    check_output("mid reset key_valid", 32'(key_valid), 32'd0);
    check_output("mid reset key_code", 32'(key_code), 32'd0);
    check_output("mid reset key_down", 32'(key_down), 32'd0);
    check_output("mid reset number", number, 32'd0);
    repeat (2) @(negedge clock);
    valid_count = 0;
    reset_n = 1'b1;
    wait_for_valid("keyA again");
    check_output("keyA again key_code", 32'(cap_code), 32'hA);
    check_output("keyA again number", cap_number, 32'h0000_000A);
    key_mat[0][3] = 1'b0;
    wait_for_release("keyA again", cyc);

    // Full keypad walk from a cleared number register.
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].r, vecs[i].c, $sformatf("vec %0d", i));
      check_output($sformatf("vec %0d accept count", i), valid_count, 1);
      check_output($sformatf("vec %0d key_code", i), 32'(cap_code), 32'(vecs[i].exp_code));
      check_output($sformatf("vec %0d number", i), cap_number, vecs[i].exp_number);
      check_output($sformatf("vec %0d held code", i), 32'(key_code), 32'(vecs[i].exp_code));
    end

`ifdef KEYPAD_CLEAR_KEY_EN
    // Clear key: 3 then D leaves number at zero.
    pulse_reset();
    apply_stimulus(2'd0, 2'd2, "clear 3");
    check_output("clear 3 number", cap_number, 32'h0000_0003);
    apply_stimulus(2'd3, 2'd3, "clear D");
    check_output("clear D key_code", 32'(cap_code), 32'hD);
    check_output("clear D number", cap_number, 32'h0000_0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 7-segment display driver: drives the 4 columns of a 4x4 hex keypad one at a time (active-low), reads the 4 row lines back, debounces, and decodes a single key press to a 4-bit hex code.
- Accepted digits shift into a 32-bit number register.
- That register feeds the display driver's 32-bit input directly, so typed digits appear on the 8-digit display.

Parameters:
- SCAN_DIV, 4, clock cycles per scan tick; minimum 2. Column settle time and sampling rate.
- DEBOUNCE_TICKS, 3, consecutive identical tick samples required to accept a press or a release; minimum 1.

Ports:
- clock  input  1  system clock; all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- row  input  4  keypad row lines, active-low, pulled up externally, asynchronous to clock
- col  output  4  keypad column drive, active-low, exactly one bit low at all times
- key_valid  output  1  one-clock pulse when a debounced press is accepted
- key_code  output  4  hex code of the last accepted key; held until the next accept
- key_down  output  1  high from accept until the debounced release completes
- number  output  32  digit shift register; new code enters bits [3:0]

Behaviour:
- Reset (async, reset_n=0):
  - state=SCAN, col_idx=0, col=4'b1110, key_valid=0, key_code=0, key_down=0, number=0.
  - Tick counter=0; synchronizer flops=4'b1111.
- row passes through a 2-flop synchronizer; rs is the synchronized value.
- Tick:
  - Counter runs 0..SCAN_DIV-1 and wraps; tick=1 for one clock when counter==SCAN_DIV-1.
  - Counter free-runs in all states.
- col = ~(4'b0001 << col_idx), registered.
- SCAN, on tick:
  - rs has exactly one zero bit: save rs as pattern, cnt=1. If DEBOUNCE_TICKS==1 go to PRESSED, else go to DEBOUNCE.
  - rs==4'b1111, or two or more zero bits (ghosting or multi-press): col_idx=col_idx+1, wrapping 3 to 0. Stay in SCAN.
- DEBOUNCE, column held, on tick:
  - rs==pattern: cnt=cnt+1. When cnt reaches DEBOUNCE_TICKS, go to PRESSED.
  - rs differs: go to SCAN with col_idx+1. No output change.
- PRESSED, exactly one clock:
  - key_valid=1 for this one clock.
  - key_code=decode(row_idx, col_idx).
  - number={number[27:0], code}.
  - key_down=1; cnt=0; go to RELEASE.
- RELEASE, column held, on tick:
  - rs==4'b1111: cnt=cnt+1.
  - Any other value: cnt=0.
  - When cnt reaches DEBOUNCE_TICKS: key_down=0, col_idx=col_idx+1, go to SCAN.
- Decode, row-major, r = index of the zero bit in pattern, c = col_idx:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Row and column behaviour:
  - A second key pressed while in RELEASE is ignored until all keys are released.
  - Holding a key produces exactly one key_valid.
- Bit shifted out of number[31:28] is discarded; no saturation.
- Latency: accept occurs at most 2 + SCAN_DIV*DEBOUNCE_TICKS clocks after the row edge, measured from the tick where the column is first sampled low.
- reset_n asserted mid-operation: all state returns to reset values immediately. A key still held after reset release is re-detected as a new press.

Optional Feature:
- Macro KEYPAD_CLEAR_KEY_EN.
- Defined:
  - Key D (r3,c3) in PRESSED sets number=0 instead of shifting.
  - key_code=4'hD and key_valid still pulses.
- Undefined: D shifts in like every other key.

Test Plan:
- Reset with all rows high → col=1110, number=0, key_valid=0; col steps 1101, 1011, 0111, 1110 once per SCAN_DIV clocks.
- Hold key 5 (row1 low when col=1101) for 40 clocks, then release → exactly one key_valid; key_code=5; number=0x00000005; key_down falls DEBOUNCE_TICKS ticks after release.
- Press 1,2,3 … 9 (nine keys), fully releasing each → number=0x23456789; the first digit is shifted out.
- Key 7 bounces with row2 low for 1 tick then high, repeated → no key_valid; scan resumes stepping columns.
- Rows 0 and 2 low together on one column → no accept; col keeps rotating.
- Assert reset_n=0 during RELEASE of key A → outputs return to reset values at once; key still held after release of reset → new accept with key_code=A and number=0x0000000A.
- With KEYPAD_CLEAR_KEY_EN: enter 3, then D → number=0 after D; key_code=D.
